// File: rtl/izhikevich_state_update_if.sv
// Handshake bundle between the dv/dw calculation stages, the state-update block and its consumer.
// The master side drives increments and out_ready; the slave side returns the neuron state.
interface izhikevich_state_update_if #(
    parameter int N     = 20,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     dv;
    logic [N-1:0]     dw;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     v;
    logic [N-1:0]     w;
    logic             spike;
    logic [CNT_W-1:0] spike_count;

    modport master (
        output in_valid, dv, dw, out_ready,
        input  in_ready, out_valid, v, w, spike, spike_count
    );

    modport slave (
        input  in_valid, dv, dw, out_ready,
        output in_ready, out_valid, v, w, spike, spike_count
    );
endinterface

// File: rtl/izhikevich_state_update.sv
// One Euler step of the Izhikevich neuron (v += dv, w += dw) with spike detection,
// after-spike reset and a saturating spike counter. Sign-magnitude arithmetic throughout.
module izhikevich_state_update #(
    parameter int           N      = 20,
    parameter int           Q      = 8,
    parameter logic [N-1:0] V_TH   = {1'b0, (N-1)'(30 << Q)},
    parameter logic [N-1:0] C      = {1'b1, (N-1)'(65 << Q)},
    parameter logic [N-1:0] D      = {1'b0, (N-1)'(8 << Q)},
    parameter logic [N-1:0] V_INIT = {1'b1, (N-1)'(65 << Q)},
    parameter logic [N-1:0] W_INIT = {1'b1, (N-1)'(13 << Q)},
    parameter int           CNT_W  = 16
) (
    input logic                      clk,
    input logic                      reset,
    izhikevich_state_update_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ADD, CMP, HOLD} state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     dv_p0, dw_p0;
    logic [N-1:0]     v_sum_p1, w_sum_p1;
    logic [N-1:0]     v_q, w_q;
    logic             spike_q;
    logic [CNT_W-1:0] cnt_q;
    logic             spike_hit;

    function automatic logic [N-1:0] norm(input logic [N-1:0] x);
        return (x[N-2:0] == '0) ? '0 : x;
    endfunction

    function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] mag_sum;
        logic [N-2:0] mag;
        logic         sgn;
        mag_sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
        if (a[N-1] == b[N-1]) begin
            sgn = a[N-1];
            mag = mag_sum[N-1] ? '1 : mag_sum[N-2:0];
        end else if (a[N-2:0] >= b[N-2:0]) begin
            sgn = a[N-1];
            mag = a[N-2:0] - b[N-2:0];
        end else begin
            sgn = b[N-1];
            mag = b[N-2:0] - a[N-2:0];
        end
        return norm({sgn, mag});
    endfunction

    function automatic logic signed [N:0] to_tc(input logic [N-1:0] x);
        logic signed [N:0] m;
        m = signed'({2'b00, x[N-2:0]});
        return x[N-1] ? -m : m;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = ADD;
            end
            ADD:  state_nxt = CMP;
            CMP:  state_nxt = HOLD;
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0: capture increments on accept; p1: saturating sums of state and increments
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            dv_p0 <= norm(bus.dv);
            dw_p0 <= norm(bus.dw);
        end
        if (state == ADD) begin
            v_sum_p1 <= sat_add(v_q, dv_p0);
            w_sum_p1 <= sat_add(w_q, dw_p0);
        end
    end

    assign spike_hit = (to_tc(v_sum_p1) >= to_tc(V_TH));

    // Neuron state commits only at the CMP edge so upstream stages see stable v/w
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q     <= V_INIT;
            w_q     <= W_INIT;
            spike_q <= 1'b0;
            cnt_q   <= '0;
        end else if (state == CMP) begin
            if (spike_hit) begin
                v_q     <= C;
                w_q     <= sat_add(w_sum_p1, D);
                spike_q <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                v_q     <= v_sum_p1;
                w_q     <= w_sum_p1;
                spike_q <= 1'b0;
            end
        end else if (state == HOLD && bus.out_ready) begin
            spike_q <= 1'b0;
        end
    end

    assign bus.v           = v_q;
    assign bus.w           = w_q;
    assign bus.spike       = spike_q;
    assign bus.spike_count = cnt_q;

endmodule

// File: tb/tb_izhikevich_state_update.sv
// Directed bench for izhikevich_state_update: an integer-valued neuron model predicts each
// result; a negedge monitor checks every output cycle against it.
module tb_izhikevich_state_update;

    localparam int           MAXM   = (1 << 19) - 1;
    localparam logic [19:0]  V_INIT = 20'h84100;
    localparam logic [19:0]  W_INIT = 20'h80D00;

    typedef struct {
        logic [19:0] v;
        logic [19:0] w;
        logic        spike;
        logic [15:0] cnt;
        longint      t;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t exp_q[$];
    int   mv, mw;
    int   mcnt;

    logic [19:0] cur_v = V_INIT, cur_w = W_INIT;
    logic        cur_spk = 1'b0;
    logic [15:0] cur_cnt = '0;
    logic        prev_ov = 1'b0;

    izhikevich_state_update_if #(.N(20), .CNT_W(16)) bus ();

    izhikevich_state_update dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic int sm2i(input logic [19:0] x);
        int m;
        m = int'(x[18:0]);
        return x[19] ? -m : m;
    endfunction

    function automatic logic [19:0] i2sm(input int y);
        int c;
        c = (y > MAXM) ? MAXM : ((y < -MAXM) ? -MAXM : y);
        return (c < 0) ? {1'b1, 19'(-c)} : {1'b0, 19'(c)};
    endfunction

    function automatic int clamp(input int y);
        return (y > MAXM) ? MAXM : ((y < -MAXM) ? -MAXM : y);
    endfunction

    // Real-valued neuron step on integers scaled by 256
    task automatic model_step(input logic [19:0] d_v, input logic [19:0] d_w, output exp_t e);
        int vs, ws;
        vs = clamp(mv + sm2i(d_v));
        ws = clamp(mw + sm2i(d_w));
        if (vs >= 30 * 256) begin
            mv = -65 * 256;
            mw = clamp(ws + 8 * 256);
            if (mcnt < 65535) mcnt++;
            e.spike = 1'b1;
        end else begin
            mv = vs;
            mw = ws;
            e.spike = 1'b0;
        end
        e.v   = i2sm(mv);
        e.w   = i2sm(mw);
        e.cnt = 16'(mcnt);
        e.t   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mv   = -65 * 256;
        mw   = -13 * 256;
        mcnt = 0;
    endtask

    task automatic send(input logic [19:0] d_v, input logic [19:0] d_w);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dv = d_v;
        bus.dw = d_w;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("accept");
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_step(d_v, d_w, e);
            e.t = longint'($time);
            exp_q.push_back(e);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("done");
    endtask

    // Monitor: result values at out_valid rise, stability everywhere else
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            cur_v   = V_INIT;
            cur_w   = W_INIT;
            cur_spk = 1'b0;
            cur_cnt = '0;
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_v", {12'd0, bus.v}, {12'd0, e.v});
                    check("res_w", {12'd0, bus.w}, {12'd0, e.w});
                    check("res_spike", {31'd0, bus.spike}, {31'd0, e.spike});
                    check("res_cnt", {16'd0, bus.spike_count}, {16'd0, e.cnt});
                    check("latency", 32'(longint'($time) - e.t), 32'd25);
                    cur_v   = e.v;
                    cur_w   = e.w;
                    cur_spk = e.spike;
                    cur_cnt = e.cnt;
                end
            end else begin
                check("v_stable", {12'd0, bus.v}, {12'd0, cur_v});
                check("w_stable", {12'd0, bus.w}, {12'd0, cur_w});
                check("cnt_stable", {16'd0, bus.spike_count}, {16'd0, cur_cnt});
                if (bus.out_valid) check("spike_held", {31'd0, bus.spike}, {31'd0, cur_spk});
                else               check("spike_idle", {31'd0, bus.spike}, 32'd0);
            end
            if (bus.out_valid) check("in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.dv        = '0;
        bus.dw        = '0;
        bus.out_ready = 1'b1;

        // Reset state
        do_reset();
        check("rst_v", {12'd0, bus.v}, 32'h84100);
        check("rst_w", {12'd0, bus.w}, 32'h80D00);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_spike", {31'd0, bus.spike}, 32'd0);
        check("rst_cnt", {16'd0, bus.spike_count}, 32'd0);

        // Sub-threshold step
        send(20'h00100, 20'h00000);
        wait_done();
        check("sub_v", {12'd0, bus.v}, 32'h84000);
        check("sub_w", {12'd0, bus.w}, 32'h80D00);

        // Spike exactly at threshold, then a quiet step
        do_reset();
        send(20'h05F00, 20'h00000);
        wait_done();
        check("spk_v", {12'd0, bus.v}, 32'h84100);
        check("spk_w", {12'd0, bus.w}, 32'h80500);
        check("spk_cnt", {16'd0, bus.spike_count}, 32'd1);
        send(20'h00000, 20'h00000);
        wait_done();
        check("post_spk_cnt", {16'd0, bus.spike_count}, 32'd1);

        // Saturation on w, then a plain v step
        do_reset();
        send(20'h00000, 20'h7FFFF);
        wait_done();
        check("sat_w1", {12'd0, bus.w}, 32'h7F2FF);
        send(20'h00000, 20'h7FFFF);
        wait_done();
        check("sat_w2", {12'd0, bus.w}, 32'h7FFFF);
        do_reset();
        send(20'h00D00, 20'h00000);
        wait_done();
        check("step_v", {12'd0, bus.v}, 32'h83400);

        // Backpressure with an ignored in_valid pulse
        do_reset();
        bus.out_ready = 1'b0;
        send(20'h00100, 20'h00000);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            if (!seen) fail_now("bp_out_valid");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.dv = 20'h00100;
                bus.dw = 20'h00000;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ov", {31'd0, bus.out_valid}, 32'd0);
        check("bp_release_ir", {31'd0, bus.in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        check("bp_v", {12'd0, bus.v}, 32'h84000);

        // Reset while in ADD discards the update
        do_reset();
        send(20'h05F00, 20'h00000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_v", {12'd0, bus.v}, 32'h84100);
        @(negedge clk);
        reset = 1'b0;
        mv   = -65 * 256;
        mw   = -13 * 256;
        mcnt = 0;
        check("midrst_cnt", {16'd0, bus.spike_count}, 32'd0);
        check("midrst_ov", {31'd0, bus.out_valid}, 32'd0);
        repeat (4) @(negedge clk);

        // Negative zero normalisation
        send(20'h04200, 20'h00000);
        wait_done();
        check("pos_one_v", {12'd0, bus.v}, 32'h00100);
        send(20'h80100, 20'h00000);
        wait_done();
        check("zero_v", {12'd0, bus.v}, 32'h00000);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
